tx_transmitter: RTL and testbench

//  Serial frame transmitter, the upstream peer of rx_receiver. Latches a 2-bit dest ID, a 2-bit src ID
//  and a 128-bit payload on a start request. Drives preamble, header, payload and CRC-16 onto the shared

---
 rtl/tx_transmitter_pkg.sv | 45 ++++
 rtl/tx_transmitter_if.sv | 29 ++
 rtl/tx_transmitter_crc16_serial.sv | 40 ++++
 rtl/tx_transmitter.sv | 212 +++++++++++++++++++++
 tb/tb_tx_transmitter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/tx_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// tx_transmitter_pkg
// Shared definitions for the serial frame transmitter and its CRC engine:
// field widths, framing constants, per-state bit-count reload values, the FSM
// state encoding and the single-bit CRC-16-CCITT update function.
// -----------------------------------------------------------------------------
package tx_transmitter_pkg;

    localparam int ID_W      = 2;
    localparam int PAYLOAD_W = 128;
    localparam int CRC_W     = 16;
    localparam int SHIFT_W   = 2 * ID_W + PAYLOAD_W;   // header + payload bits
    localparam int CNT_W     = 8;
    localparam int GAP_BITS  = 8;                      // must be >= 1

    localparam logic [7:0]       PREAMBLE   = 8'h7E;
    localparam logic [CRC_W-1:0] CRC_POLY   = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT   = 16'hFFFF;
    localparam logic             IDLE_LEVEL = 1'b1;

    // Down-counter reload values: a state lasting N bits is entered with N-1.
    localparam logic [CNT_W-1:0] PRE_LOAD = 8'd7;
    localparam logic [CNT_W-1:0] HDR_LOAD = 8'd3;
    localparam logic [CNT_W-1:0] PAY_LOAD = 8'd127;
    localparam logic [CNT_W-1:0] CRC_LOAD = 8'd15;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CRC  = 3'd4,
        ST_GAP  = 3'd5
    } tx_state_e;

    // One step of the unreflected serial CRC-16 LFSR; feedback = crc[15] ^ bit.
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                    input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        crc16_step = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/tx_transmitter_if.sv
// -----------------------------------------------------------------------------
// tx_transmitter_if
// Request/field inputs and serial/status outputs of the frame transmitter.
//   master : the requester (drives start/dest_id/src_id/payload)
//   slave  : the transmitter (drives tx_line/tx_oe/busy/done)
// -----------------------------------------------------------------------------
interface tx_transmitter_if;
    import tx_transmitter_pkg::*;

    logic                 start;
    logic [ID_W-1:0]      dest_id;
    logic [ID_W-1:0]      src_id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 tx_line;
    logic                 tx_oe;
    logic                 busy;
    logic                 done;

    modport master (
        output start, dest_id, src_id, payload,
        input  tx_line, tx_oe, busy, done
    );

    modport slave (
        input  start, dest_id, src_id, payload,
        output tx_line, tx_oe, busy, done
    );

endinterface

// File: rtl/tx_transmitter_crc16_serial.sv
// -----------------------------------------------------------------------------
// crc16_serial
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, no final XOR). The same
// engine sits in the receiver so both ends compute the CRC identically.
//   clk    in  bit clock
//   rst_n  in  asynchronous active-low reset (crc -> CRC_INIT)
//   clr    in  synchronous reload of CRC_INIT (priority over en)
//   en     in  fold bit_in into the CRC on this edge
//   bit_in in  serial data bit
//   crc    out current CRC register
// -----------------------------------------------------------------------------
module crc16_serial
    import tx_transmitter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;

    // CRC register: reset/clear to the seed, advance one bit when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/tx_transmitter.sv
// -----------------------------------------------------------------------------
// tx_transmitter
// Serial frame transmitter, one bit per clk, MSB first:
//   PREAMBLE[7:0] | dest_id[1:0] | src_id[1:0] | payload[127:0] | crc[15:0]
// followed by GAP_BITS idle bit-times. Fields are latched on accept (start=1
// in IDLE); later input changes and further start pulses do not disturb the
// frame in flight.
// Ports:
//   clk            in  bit clock
//   rst_n          in  asynchronous active-low reset; aborts any frame
//   tx_bus.start   in  transmit request, sampled only in IDLE
//   tx_bus.dest_id in  destination ID
//   tx_bus.src_id  in  source ID
//   tx_bus.payload in  payload, bit 127 sent first
//   tx_bus.tx_line out serial data (IDLE_LEVEL when not transmitting)
//   tx_bus.tx_oe   out pad output enable, high in PRE/HDR/PAY/CRC
//   tx_bus.busy    out high from accept until the end of GAP
//   tx_bus.done    out one-cycle pulse on the first GAP cycle
// -----------------------------------------------------------------------------
module tx_transmitter
    import tx_transmitter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    tx_transmitter_if.slave    tx_bus
);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_shift_nxt;
    logic [CRC_W-1:0]   w_crc;
    logic [CRC_W-1:0]   w_crc_after;
    logic               w_accept;
    logic               w_shifting;
    logic               w_last;
    logic [CNT_W-1:0]   w_cnt_dec;

    logic               r_tx_line;
    logic               r_tx_oe;
    logic               r_busy;
    logic               r_done;
    logic               w_tx_line_nxt;
    logic               w_tx_oe_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    assign w_accept   = (r_state == ST_IDLE) && tx_bus.start;
    assign w_shifting = (r_state == ST_HDR) || (r_state == ST_PAY);
    assign w_last     = (r_cnt == 8'd0);
    assign w_cnt_dec  = r_cnt - 8'd1;

    // The bit on the line during HDR/PAY is r_shift[MSB]; it feeds the CRC.
    crc16_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (r_state == ST_IDLE),
        .en     (w_shifting),
        .bit_in (r_shift[SHIFT_W-1]),
        .crc    (w_crc)
    );

    // CRC value after this edge; lets the first CRC bit be registered on the
    // same edge that folds in the last payload bit.
    assign w_crc_after = w_shifting ? crc16_step(w_crc, r_shift[SHIFT_W-1]) : w_crc;

    // State register and per-state bit down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: each state lasts until its counter reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_dec;
        case (r_state)
            ST_IDLE: begin
                if (tx_bus.start) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = PRE_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            ST_PRE: begin
                if (w_last) begin
                    w_state_nxt = ST_HDR;
                    w_cnt_nxt   = HDR_LOAD;
                end else begin
                    w_state_nxt = ST_PRE;
                end
            end
            ST_HDR: begin
                if (w_last) begin
                    w_state_nxt = ST_PAY;
                    w_cnt_nxt   = PAY_LOAD;
                end else begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_PAY: begin
                if (w_last) begin
                    w_state_nxt = ST_CRC;
                    w_cnt_nxt   = CRC_LOAD;
                end else begin
                    w_state_nxt = ST_PAY;
                end
            end
            ST_CRC: begin
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_state_nxt = ST_CRC;
                end
            end
            ST_GAP: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Shift register next value: load fields on accept, shift left in HDR/PAY.
    always_comb begin
        if (w_accept) begin
            w_shift_nxt = {tx_bus.dest_id, tx_bus.src_id, tx_bus.payload};
        end else if (w_shifting) begin
            w_shift_nxt = {r_shift[SHIFT_W-2:0], 1'b0};
        end else begin
            w_shift_nxt = r_shift;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_shift_nxt;
        end
    end

    // Output decode from the state/count being entered, so the registered
    // outputs carry the bit belonging to the next bit-time.
    always_comb begin
        w_tx_line_nxt = IDLE_LEVEL;
        w_tx_oe_nxt   = 1'b0;
        case (w_state_nxt)
            ST_PRE: begin
                w_tx_line_nxt = PREAMBLE[w_cnt_nxt[2:0]];
                w_tx_oe_nxt   = 1'b1;
            end
            ST_HDR, ST_PAY: begin
                w_tx_line_nxt = w_shift_nxt[SHIFT_W-1];
                w_tx_oe_nxt   = 1'b1;
            end
            ST_CRC: begin
                w_tx_line_nxt = w_crc_after[w_cnt_nxt[3:0]];
                w_tx_oe_nxt   = 1'b1;
            end
            ST_GAP: begin
                w_tx_line_nxt = IDLE_LEVEL;
                w_tx_oe_nxt   = 1'b0;
            end
            default: begin
                w_tx_line_nxt = IDLE_LEVEL;
                w_tx_oe_nxt   = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_GAP) && (r_state != ST_GAP);
    end

    // Output registers; reset returns the pad to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_line <= IDLE_LEVEL;
            r_tx_oe   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tx_line <= w_tx_line_nxt;
            r_tx_oe   <= w_tx_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign tx_bus.tx_line = r_tx_line;
    assign tx_bus.tx_oe   = r_tx_oe;
    assign tx_bus.busy    = r_busy;
    assign tx_bus.done    = r_done;

endmodule

// File: tb/tb_tx_transmitter.sv
// -----------------------------------------------------------------------------
// tb_tx_transmitter
// Directed bench for tx_transmitter: reset/idle, single frames against a
// reference frame builder, field decode of a captured frame, start pulses and
// input changes mid-frame, back-to-back frames, and asynchronous reset abort.
// -----------------------------------------------------------------------------
module tb_tx_transmitter;
    import tx_transmitter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tx_transmitter_if bus ();

    tx_transmitter u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx_bus (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [127:0] P3 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic [155:0] stream;
    logic [155:0] exp_t2;
    int           dones;
    int           bad;
    int           d1, d2, r2, last_hi1;
    logic         prev_oe;
    logic [7:0]   pre2;

    // Single comparison point: counts and reports mismatches.
    task automatic chk_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference CRC-16-CCITT over header+payload, MSB first.
    function automatic logic [15:0] model_crc(input logic [131:0] bits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 131; i >= 0; i--) begin
            if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [155:0] model_frame(input logic [1:0] d, input logic [1:0] s,
                                                 input logic [127:0] p);
        return {8'h7E, d, s, p, model_crc({d, s, p})};
    endfunction

    // Send one frame and capture its 156 bits plus the gap. At bit index
    // disturb_at, start is re-pulsed and the inputs are inverted.
    task automatic run_frame(input string tag, input logic [1:0] d, input logic [1:0] s,
                             input logic [127:0] p, input int disturb_at,
                             output logic [155:0] strm);
        int flag_bad;
        int n_done;
        int busy_bad;
        flag_bad = 0;
        n_done   = 0;
        busy_bad = 0;
        bus.dest_id = d;
        bus.src_id  = s;
        bus.payload = p;
        bus.start   = 1'b1;
        tick;
        bus.start   = 1'b0;
        for (int i = 0; i < 156; i++) begin
            strm[155 - i] = bus.tx_line;
            if (!(bus.tx_oe && bus.busy)) flag_bad++;
            if (bus.done) n_done++;
            if (i == disturb_at) begin
                bus.start   = 1'b1;
                bus.dest_id = ~d;
                bus.src_id  = ~s;
                bus.payload = ~p;
            end
            if (i == disturb_at + 1) bus.start = 1'b0;
            tick;
        end
        chk_eq({tag, "_frame_flags"}, flag_bad, 0);
        chk_eq({tag, "_gap_first"}, {bus.done, bus.tx_oe, bus.tx_line}, 3'b101);
        for (int g = 0; g < GAP_BITS; g++) begin
            if (bus.done) n_done++;
            if (!bus.busy || bus.tx_oe || !bus.tx_line) busy_bad++;
            tick;
        end
        chk_eq({tag, "_gap_hold"}, busy_bad, 0);
        chk_eq({tag, "_busy_end"}, {bus.busy, bus.tx_oe, bus.tx_line}, 3'b001);
        chk_eq({tag, "_done_count"}, n_done, 1);
    endtask

    initial begin
        // 1. Reset with start asserted, then idle.
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.dest_id = 2'b00;
        bus.src_id  = 2'b00;
        bus.payload = 128'h0;
        repeat (3) tick;
        chk_eq("t1_rst_line", bus.tx_line, 1'b1);
        chk_eq("t1_rst_oe",   bus.tx_oe,   1'b0);
        chk_eq("t1_rst_busy", bus.busy,    1'b0);
        chk_eq("t1_rst_done", bus.done,    1'b0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        bad = 0;
        repeat (20) begin
            tick;
            if ({bus.tx_line, bus.tx_oe, bus.busy, bus.done} !== 4'b1000) bad++;
        end
        chk_eq("t1_idle_hold", bad, 0);

        // 2. Single frame dest=01 src=10 payload=0.
        run_frame("t2", 2'b01, 2'b10, 128'h0, -1, stream);
        exp_t2 = model_frame(2'b01, 2'b10, 128'h0);
        chk_eq("t2_pre",   stream[155:148], 8'h7E);
        chk_eq("t2_hdr",   stream[147:144], 4'b0110);
        chk_eq("t2_pay",   stream[143:16],  128'h0);
        chk_eq("t2_crc",   stream[15:0],    model_crc({2'b01, 2'b10, 128'h0}));
        chk_eq("t2_frame", stream, exp_t2);

        // 3. Decode a captured frame as the receiver would.
        run_frame("t3", 2'b11, 2'b00, P3, -1, stream);
        chk_eq("t3_dest",  stream[147:146], 2'b11);
        chk_eq("t3_src",   stream[145:144], 2'b00);
        chk_eq("t3_pay",   stream[143:16],  P3);
        chk_eq("t3_crcok", stream[15:0],    model_crc(stream[147:16]));
        chk_eq("t3_frame", stream, model_frame(2'b11, 2'b00, P3));

        // 4. start re-pulsed and inputs changed at bit 40.
        run_frame("t4", 2'b01, 2'b10, 128'h0, 40, stream);
        chk_eq("t4_frame", stream, exp_t2);

        // 5. start held high: back-to-back frames.
        bus.dest_id = 2'b01;
        bus.src_id  = 2'b10;
        bus.payload = 128'h0;
        bus.start   = 1'b1;
        tick;
        d1 = -1; d2 = -1; r2 = -1; last_hi1 = -1;
        prev_oe = 1'b1;
        pre2    = 8'h00;
        for (int c = 0; c < 400 && d2 < 0; c++) begin
            if (bus.done) begin
                if (d1 < 0) d1 = c;
                else        d2 = c;
            end
            if (bus.tx_oe && !prev_oe && r2 < 0) r2 = c;
            if (bus.tx_oe && r2 < 0) last_hi1 = c;
            if (r2 >= 0 && c - r2 < 8) pre2[7 - (c - r2)] = bus.tx_line;
            prev_oe = bus.tx_oe;
            tick;
        end
        bus.start = 1'b0;
        chk_eq("t5_done1_lat", d1, 156);
        chk_eq("t5_done_gap",  d2 - d1, 165);
        chk_eq("t5_idle_gap",  r2 - last_hi1 - 1, GAP_BITS + 1);
        chk_eq("t5_pre2",      pre2, 8'h7E);
        for (int k = 0; k < 400 && bus.busy; k++) tick;
        chk_eq("t5_drain", bus.busy, 1'b0);

        // 6. Asynchronous reset at payload bit 60, then a clean frame.
        bus.dest_id = 2'b11;
        bus.src_id  = 2'b00;
        bus.payload = P3;
        bus.start   = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (72) tick;
        chk_eq("t6_mid_oe", bus.tx_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_async_rst", {bus.tx_line, bus.tx_oe, bus.busy, bus.done}, 4'b1000);
        #2;
        rst_n = 1'b1;
        tick;
        chk_eq("t6_post_idle", {bus.tx_line, bus.tx_oe, bus.busy, bus.done}, 4'b1000);
        run_frame("t6", 2'b11, 2'b00, P3, -1, stream);
        chk_eq("t6_frame", stream, model_frame(2'b11, 2'b00, P3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
